// File: rtl/shift_unit_seq_if.sv
// Request/result bundle for the sequential shifter: operand and controls in,
// shifted word and bit buckets out, each side with its own valid/ready pair.
interface shift_unit_seq_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] amount;
    logic [1:0]       mode;
    logic             fill_left;
    logic             fill_right;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             bb_left;
    logic             bb_right;
    logic             busy;

    modport master (
        output in_valid, data_in, amount, mode, fill_left, fill_right, out_ready,
        input  in_ready, out_valid, data_out, bb_left, bb_right, busy
    );

    modport slave (
        input  in_valid, data_in, amount, mode, fill_left, fill_right, out_ready,
        output in_ready, out_valid, data_out, bb_left, bb_right, busy
    );
endinterface

// File: rtl/shift_unit_seq.sv
// Sequential shift/rotate unit: accepts one request, shifts one bit per clock
// for 'amount' clocks, then holds the result until the consumer takes it.
module shift_unit_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    shift_unit_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [AMT_W-1:0] count_reg, count_next;
    logic [1:0]       mode_reg, mode_next;
    logic             fill_left_reg, fill_left_next;
    logic             fill_right_reg, fill_right_next;
    logic             bb_left_reg, bb_left_next;
    logic             bb_right_reg, bb_right_next;

    logic [WIDTH-1:0] shl_vec;
    logic [WIDTH-1:0] shr_vec;
    logic             shr_msb;

    // Bit entering at the MSB on any right-going step depends on the mode
    always_comb begin
        shr_msb = 1'b0;
        case (mode_reg)
            MODE_LSR: shr_msb = fill_left_reg;
            MODE_ASR: shr_msb = data_reg[WIDTH-1];
            MODE_ROR: shr_msb = data_reg[0];
            default:  shr_msb = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bits
            if (gi == 0) begin : g_lsb
                assign shl_vec[gi] = fill_right_reg;
            end else begin : g_low
                assign shl_vec[gi] = data_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_msb
                assign shr_vec[gi] = shr_msb;
            end else begin : g_high
                assign shr_vec[gi] = data_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        data_next       = data_reg;
        count_next      = count_reg;
        mode_next       = mode_reg;
        fill_left_next  = fill_left_reg;
        fill_right_next = fill_right_reg;
        bb_left_next    = bb_left_reg;
        bb_right_next   = bb_right_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    data_next       = bus.data_in;
                    mode_next       = bus.mode;
                    fill_left_next  = bus.fill_left;
                    fill_right_next = bus.fill_right;
                    count_next      = bus.amount;
                    bb_left_next    = 1'b0;
                    bb_right_next   = 1'b0;
                    state_next      = (bus.amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                count_next = count_reg - AMT_W'(1);
                if (mode_reg == MODE_LSL) begin
                    bb_left_next = data_reg[WIDTH-1];
                    data_next    = shl_vec;
                end else begin
                    bb_right_next = data_reg[0];
                    data_next     = shr_vec;
                end
                if (count_reg == AMT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            data_reg       <= '0;
            count_reg      <= '0;
            mode_reg       <= 2'b00;
            fill_left_reg  <= 1'b0;
            fill_right_reg <= 1'b0;
            bb_left_reg    <= 1'b0;
            bb_right_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            data_reg       <= data_next;
            count_reg      <= count_next;
            mode_reg       <= mode_next;
            fill_left_reg  <= fill_left_next;
            fill_right_reg <= fill_right_next;
            bb_left_reg    <= bb_left_next;
            bb_right_reg   <= bb_right_next;
        end
    end

    // Handshake outputs decode from state alone, so no input-to-output path
    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.data_out  = data_reg;
    assign bus.bb_left   = bb_left_reg;
    assign bus.bb_right  = bb_right_reg;
endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: an 8-bit unit for the functional cases
// and a 4-bit unit swept over every single-step left/right combination.
module tb_shift_unit_seq;
    logic clk;
    logic reset_n;

    int n_cmp;
    int n_bad;
    int num_wrong;

    shift_unit_seq_if #(.WIDTH(8), .AMT_W(4)) bus8 ();
    shift_unit_seq_if #(.WIDTH(4), .AMT_W(3)) bus4 ();

    shift_unit_seq #(.WIDTH(8), .AMT_W(4)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8.slave)
    );

    shift_unit_seq #(.WIDTH(4), .AMT_W(3)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full request/result exchange on the 8-bit unit; entered at a negedge with the unit idle
    task automatic run8(input logic [7:0] d, input logic [3:0] amt, input logic [1:0] md,
                        input logic fl, input logic fr,
                        input logic [7:0] exp_d, input logic exp_bl, input logic exp_br);
        int lat;
        chk("in_ready_idle", 32'(bus8.in_ready), 32'd1);
        bus8.in_valid   = 1'b1;
        bus8.data_in    = d;
        bus8.amount     = amt;
        bus8.mode       = md;
        bus8.fill_left  = fl;
        bus8.fill_right = fr;
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        bus8.data_in = ~d;
        @(negedge clk);
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", 32'(lat), 32'(amt));
        chk("data_out", 32'(bus8.data_out), 32'(exp_d));
        chk("bb_left", 32'(bus8.bb_left), 32'(exp_bl));
        chk("bb_right", 32'(bus8.bb_right), 32'(exp_br));
        $display("txn w8 mode=%0d data_in=%h amount=%0d -> data_out=%h bb_left=%b bb_right=%b latency=%0d",
                 md, d, amt, bus8.data_out, bus8.bb_left, bus8.bb_right, lat);
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1 bus8.out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after", 32'(bus8.in_ready), 32'd1);
        chk("out_valid_after", 32'(bus8.out_valid), 32'd0);
    endtask

    task automatic run4(input logic [1:0] md, input logic fl, input logic [3:0] d, input logic fr);
        logic [5:0] exp_v;
        int lat;
        exp_v = (md == 2'b00) ? {d, fr, 1'b0} : {1'b0, fl, d};
        bus4.in_valid   = 1'b1;
        bus4.data_in    = d;
        bus4.amount     = 3'd1;
        bus4.mode       = md;
        bus4.fill_left  = fl;
        bus4.fill_right = fr;
        @(posedge clk);
        #1 bus4.in_valid = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!bus4.out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_cmp++;
        assert ({bus4.bb_left, bus4.data_out, bus4.bb_right} === exp_v && lat == 1) else begin
            n_bad++;
            num_wrong++;
            $error("FAIL w4_step mode=%0d observed=%b latency=%0d expected=%b latency=1",
                   md, {bus4.bb_left, bus4.data_out, bus4.bb_right}, lat, exp_v);
        end
        $display("txn w4 mode=%0d fl=%b d=%b fr=%b -> {bbl,q,bbr}=%b", md, fl, d, fr,
                 {bus4.bb_left, bus4.data_out, bus4.bb_right});
        bus4.out_ready = 1'b1;
        @(posedge clk);
        #1 bus4.out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] held;
        n_cmp     = 0;
        n_bad     = 0;
        num_wrong = 0;
        reset_n   = 1'b0;
        bus8.in_valid = 1'b0; bus8.data_in = '0; bus8.amount = '0; bus8.mode = 2'b00;
        bus8.fill_left = 1'b0; bus8.fill_right = 1'b0; bus8.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.data_in = '0; bus4.amount = '0; bus4.mode = 2'b00;
        bus4.fill_left = 1'b0; bus4.fill_right = 1'b0; bus4.out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_data_out", 32'(bus8.data_out), 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed single requests
        run8(8'b1011_0011, 4'd1, 2'b00, 1'b0, 1'b1, 8'b0110_0111, 1'b1, 1'b0);
        run8(8'h90, 4'd3, 2'b10, 1'b0, 1'b0, 8'hF2, 1'b0, 1'b0);
        run8(8'hA5, 4'd8, 2'b11, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
        run8(8'hFF, 4'd12, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        run8(8'h3C, 4'd0, 2'b00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        run8(8'h00, 4'd15, 2'b00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        run8(8'h80, 4'd15, 2'b10, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
        run8(8'h5A, 4'd2, 2'b01, 1'b1, 1'b0, 8'hD6, 1'b0, 1'b1);

        // Backpressure: hold DONE with a competing request present
        bus8.in_valid = 1'b1; bus8.data_in = 8'h5A; bus8.amount = 4'd2;
        bus8.mode = 2'b01; bus8.fill_left = 1'b1; bus8.fill_right = 1'b0;
        @(posedge clk);
        #1 bus8.data_in = 8'h11;
        bus8.amount = 4'd0;
        repeat (3) @(negedge clk);
        held = 8'hD6;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(bus8.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus8.in_ready), 32'd0);
            chk("bp_data_out", 32'(bus8.data_out), 32'(held));
            chk("bp_bb_right", 32'(bus8.bb_right), 32'd1);
            @(negedge clk);
        end
        $display("txn w8 backpressure held data_out=%h for 5 cycles", bus8.data_out);
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1 bus8.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(bus8.in_ready), 32'd1);
        chk("bp_release_busy", 32'(bus8.busy), 32'd0);

        // Asynchronous reset in the middle of a shift
        bus8.in_valid = 1'b1; bus8.data_in = 8'hFF; bus8.amount = 4'd10;
        bus8.mode = 2'b01; bus8.fill_left = 1'b1;
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(bus8.busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("arst_data_out", 32'(bus8.data_out), 32'h00);
        chk("arst_bb", 32'({bus8.bb_left, bus8.bb_right}), 32'd0);
        chk("arst_in_ready", 32'(bus8.in_ready), 32'd1);
        chk("arst_busy", 32'(bus8.busy), 32'd0);
        $display("txn w8 async reset mid-shift");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run8(8'h81, 4'd1, 2'b11, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b1);

        // Exhaustive single steps on the 4-bit unit
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 64; v++) begin
                logic [5:0] vec;
                vec = 6'(v);
                run4(2'(m), vec[5], vec[4:1], vec[0]);
            end
        end
        chk("num_wrong", 32'(num_wrong), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
